// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the small RISC CPU.
//   OP_*  : 3-bit opcode encodings (IR[15:13])
//   ST_*  : 3-bit sequencer state encodings
//   state_t : enumerated sequencer state built on the ST_* encodings
package cpu_pkg;

   localparam int unsigned OP_W = 3;
   localparam int unsigned ST_W = 3;

   localparam logic [OP_W-1:0] OP_HLT = 3'd0;
   localparam logic [OP_W-1:0] OP_SKZ = 3'd1;
   localparam logic [OP_W-1:0] OP_ADD = 3'd2;
   localparam logic [OP_W-1:0] OP_AND = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR = 3'd4;
   localparam logic [OP_W-1:0] OP_LDA = 3'd5;
   localparam logic [OP_W-1:0] OP_STO = 3'd6;
   localparam logic [OP_W-1:0] OP_JMP = 3'd7;

   localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
   localparam logic [ST_W-1:0] ST_F1   = 3'd1;
   localparam logic [ST_W-1:0] ST_F2   = 3'd2;
   localparam logic [ST_W-1:0] ST_DEC  = 3'd3;
   localparam logic [ST_W-1:0] ST_EX1  = 3'd4;
   localparam logic [ST_W-1:0] ST_EX2  = 3'd5;
   localparam logic [ST_W-1:0] ST_EX3  = 3'd6;
   localparam logic [ST_W-1:0] ST_HALT = 3'd7;

   typedef enum logic [ST_W-1:0] {
      S_IDLE = ST_IDLE,
      S_F1   = ST_F1,
      S_F2   = ST_F2,
      S_DEC  = ST_DEC,
      S_EX1  = ST_EX1,
      S_EX2  = ST_EX2,
      S_EX3  = ST_EX3,
      S_HALT = ST_HALT
   } state_t;

endpackage

// File: rtl/machine_ctrl_op_class_decode.sv
// op_class_decode: maps an opcode to its execution class.
//   opcode : IR[15:13]
//   is_alu : ADD/AND/XOR/LDA (memory-read operand, accumulator load)
//   is_sto : STO, is_jmp : JMP, is_skz : SKZ, is_hlt : HLT
module op_class_decode
   import cpu_pkg::*;
(
   input  logic [OP_W-1:0] opcode,
   output logic            is_alu,
   output logic            is_sto,
   output logic            is_jmp,
   output logic            is_skz,
   output logic            is_hlt
);

   always_comb begin
      is_alu = 1'b0;
      is_sto = 1'b0;
      is_jmp = 1'b0;
      is_skz = 1'b0;
      is_hlt = 1'b0;
      case (opcode)
         OP_HLT:                         is_hlt = 1'b1;
         OP_SKZ:                         is_skz = 1'b1;
         OP_ADD, OP_AND, OP_XOR, OP_LDA: is_alu = 1'b1;
         OP_STO:                         is_sto = 1'b1;
         OP_JMP:                         is_jmp = 1'b1;
         default:                        is_hlt = 1'b0;
      endcase
   end

endmodule

// File: rtl/machine_ctrl.sv
// machine_ctrl: fetch/decode/execute sequencer for the small RISC CPU.
// Steps IDLE -> F1 -> F2 -> DEC -> EX1 -> EX2 -> EX3 and emits the strobes for
// the PC, IR, accumulator and memory bus. Strobes are decoded combinationally
// from the state register so that reset drops them asynchronously.
//   clock, rst (async, active-high)
//   ena        : run enable, sampled in IDLE and EX3
//   opcode     : IR[15:13], stable from DEC to end of instruction
//   zero       : accumulator-zero flag for SKZ
//   mem_ready  : memory handshake, only used when WAIT_STATE_EN is defined
//   inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt : strobes
// Build option: WAIT_STATE_EN adds memory wait states on rd/wr states.
module machine_ctrl
   import cpu_pkg::*;
(
   input  logic            clock,
   input  logic            rst,
   input  logic            ena,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            inc_pc,
   output logic            load_pc,
   output logic            load_ir,
   output logic            load_acc,
   output logic            rd,
   output logic            wr,
   output logic            datactl_ena,
   output logic            halt
);

   state_t state, state_nxt;
   logic   is_alu, is_sto, is_jmp, is_skz, is_hlt;

   op_class_decode u_op_class_decode (
      .opcode (opcode),
      .is_alu (is_alu),
      .is_sto (is_sto),
      .is_jmp (is_jmp),
      .is_skz (is_skz),
      .is_hlt (is_hlt)
   );

   // State register
   always_ff @(posedge clock or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and strobe decode
   always_comb begin
      state_nxt   = state;
      inc_pc      = 1'b0;
      load_pc     = 1'b0;
      load_ir     = 1'b0;
      load_acc    = 1'b0;
      rd          = 1'b0;
      wr          = 1'b0;
      datactl_ena = 1'b0;
      halt        = 1'b0;

      case (state)
         S_IDLE: begin
            if (ena) state_nxt = S_F1;
         end
         S_F1: begin
            rd        = 1'b1;
            load_ir   = 1'b1;
            inc_pc    = 1'b1;
            state_nxt = S_F2;
         end
         S_F2: begin
            rd        = 1'b1;
            load_ir   = 1'b1;
            inc_pc    = 1'b1;
            state_nxt = S_DEC;
         end
         S_DEC: begin
            state_nxt = is_hlt ? S_HALT : S_EX1;
         end
         S_EX1: begin
            rd          = is_alu;
            datactl_ena = is_sto;
            load_pc     = is_jmp;
            inc_pc      = is_skz & zero;
            state_nxt   = S_EX2;
         end
         S_EX2: begin
            rd          = is_alu;
            load_acc    = is_alu;
            wr          = is_sto;
            datactl_ena = is_sto;
            load_pc     = is_jmp;
            inc_pc      = is_skz & zero;
            state_nxt   = S_EX3;
         end
         S_EX3: begin
            // STO keeps the bus driven one cycle past the write for hold time
            datactl_ena = is_sto;
            state_nxt   = ena ? S_F1 : S_IDLE;
         end
         S_HALT: begin
            halt = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

`ifdef WAIT_STATE_EN
      // Memory not ready: hold the bus strobes, suppress every load/increment
      if ((rd || wr) && !mem_ready) begin
         state_nxt = state;
         inc_pc    = 1'b0;
         load_ir   = 1'b0;
         load_acc  = 1'b0;
         load_pc   = 1'b0;
      end
`endif
   end

`ifndef WAIT_STATE_EN
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
`endif

endmodule

// File: tb/tb_machine_ctrl.sv
// tb_machine_ctrl: self-checking bench for machine_ctrl. Expected strobe
// vectors {halt,inc_pc,load_pc,load_ir,load_acc,rd,wr,datactl_ena} are pushed
// to a scoreboard queue per cycle and popped as the DUT steps.
module tb_machine_ctrl;
   import cpu_pkg::*;

   logic       clock = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b0;
   logic [2:0] opcode = OP_LDA;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt;
   logic [7:0] outs;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp;
   int         incs;

   machine_ctrl dut (
      .clock       (clock),
      .rst         (rst),
      .ena         (ena),
      .opcode      (opcode),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .inc_pc      (inc_pc),
      .load_pc     (load_pc),
      .load_ir     (load_ir),
      .load_acc    (load_acc),
      .rd          (rd),
      .wr          (wr),
      .datactl_ena (datactl_ena),
      .halt        (halt)
   );

   always #5 clock = ~clock;

   assign outs = {halt, inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena};

   localparam logic [7:0] V_ZERO = 8'h00;
   localparam logic [7:0] V_FET  = 8'h54; // inc_pc, load_ir, rd
   localparam logic [7:0] V_HALT = 8'h80;

   // Reference strobes for phase 0..5 = F1,F2,DEC,EX1,EX2,EX3
   function automatic logic [7:0] ref_out(input logic [2:0] op, input logic z, input int ph);
      logic alu;
      alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
      case (ph)
         0, 1: return V_FET;
         2:    return V_ZERO;
         3: begin
            if (alu)           return 8'h04;
            if (op == OP_STO)  return 8'h01;
            if (op == OP_JMP)  return 8'h20;
            if (op == OP_SKZ)  return z ? 8'h40 : 8'h00;
            return V_ZERO;
         end
         4: begin
            if (alu)           return 8'h0C;
            if (op == OP_STO)  return 8'h03;
            if (op == OP_JMP)  return 8'h20;
            if (op == OP_SKZ)  return z ? 8'h40 : 8'h00;
            return V_ZERO;
         end
         5:       return (op == OP_STO) ? 8'h01 : 8'h00;
         default: return V_ZERO;
      endcase
   endfunction

   task automatic push_instr(input logic [2:0] op, input logic z);
      for (int p = 0; p < 6; p++) exp_q.push_back(ref_out(op, z, p));
   endtask

   task automatic tick;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset;
      @(negedge clock);
      rst = 1'b1;
      ena = 1'b0;
      mem_ready = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset;
      @(negedge clock);
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== V_ZERO) begin
         errors++;
         $display("FAIL reset_outs got=%h exp=%h", outs, V_ZERO);
      end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) exp_q.push_back(V_ZERO);
      for (int i = 0; i < 3; i++) begin
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, outs, exp);
         end
         tick();
      end
   endtask

   // LDA: IDLE, F1..EX3, then straight back into F1
   task automatic test_lda;
      do_reset();
      opcode = OP_LDA;
      ena = 1'b1;
      exp_q.push_back(V_ZERO);
      push_instr(OP_LDA, 1'b0);
      exp_q.push_back(V_FET);
      incs = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL lda cyc=%0d got=%h exp=%h", i, outs, exp);
         end
         if (i >= 1 && i <= 6 && inc_pc === 1'b1) incs++;
         tick();
      end
      checks++;
      if (incs !== 2) begin
         errors++;
         $display("FAIL lda_inc_count got=%0d exp=2", incs);
      end
   endtask

   // SKZ with zero=1 then zero=0, back-to-back
   task automatic test_skz;
      logic zs[2];
      int   want[2];
      zs[0] = 1'b1; zs[1] = 1'b0;
      want[0] = 4;  want[1] = 2;
      do_reset();
      opcode = OP_SKZ;
      ena = 1'b1;
      #1;
      checks++;
      if (outs !== V_ZERO) begin
         errors++;
         $display("FAIL skz_idle got=%h exp=%h", outs, V_ZERO);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
         zero = zs[k];
         push_instr(OP_SKZ, zs[k]);
         incs = 0;
         for (int p = 0; p < 6; p++) begin
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
               errors++;
               $display("FAIL skz z=%0b ph=%0d got=%h exp=%h", zs[k], p, outs, exp);
            end
            if (inc_pc === 1'b1) incs++;
            tick();
         end
         checks++;
         if (incs !== want[k]) begin
            errors++;
            $display("FAIL skz_inc_count z=%0b got=%0d exp=%0d", zs[k], incs, want[k]);
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_sto;
      do_reset();
      opcode = OP_STO;
      ena = 1'b1;
      exp_q.push_back(V_ZERO);
      push_instr(OP_STO, 1'b0);
      for (int i = 0; i < 7; i++) begin
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL sto cyc=%0d got=%h exp=%h", i, outs, exp);
         end
         tick();
      end
   endtask

   task automatic test_hlt;
      do_reset();
      opcode = OP_HLT;
      ena = 1'b1;
      exp_q.push_back(V_ZERO);
      exp_q.push_back(V_FET);
      exp_q.push_back(V_FET);
      exp_q.push_back(V_ZERO);
      for (int i = 0; i < 20; i++) exp_q.push_back(V_HALT);
      for (int i = 0; i < 24; i++) begin
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL hlt cyc=%0d got=%h exp=%h", i, outs, exp);
         end
         tick();
      end
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== V_ZERO) begin
         errors++;
         $display("FAIL hlt_rst got=%h exp=%h", outs, V_ZERO);
      end
      ena = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (outs !== V_ZERO) begin
         errors++;
         $display("FAIL hlt_after_rst got=%h exp=%h", outs, V_ZERO);
      end
   endtask

   // JMP with ena dropped in EX1, then a JMP aborted by reset in EX2
   task automatic test_jmp_ena_drop;
      do_reset();
      opcode = OP_JMP;
      ena = 1'b1;
      exp_q.push_back(V_ZERO);
      push_instr(OP_JMP, 1'b0);
      exp_q.push_back(V_ZERO);
      exp_q.push_back(V_ZERO);
      for (int i = 0; i < 9; i++) begin
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL jmp_drop cyc=%0d got=%h exp=%h", i, outs, exp);
         end
         if (i == 4) ena = 1'b0;
         tick();
      end
      ena = 1'b1;
      exp_q.push_back(V_ZERO);
      for (int p = 0; p < 5; p++) exp_q.push_back(ref_out(OP_JMP, 1'b0, p));
      for (int i = 0; i < 6; i++) begin
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL jmp_pre_rst cyc=%0d got=%h exp=%h", i, outs, exp);
         end
         if (i < 5) tick();
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (outs !== V_ZERO) begin
         errors++;
         $display("FAIL jmp_async_rst got=%h exp=%h", outs, V_ZERO);
      end
      ena = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   // Mixed opcodes with no IDLE gap between instructions
   task automatic test_back_to_back;
      logic [2:0] ops[6];
      ops[0] = OP_ADD; ops[1] = OP_AND; ops[2] = OP_XOR;
      ops[3] = OP_STO; ops[4] = OP_JMP; ops[5] = OP_LDA;
      do_reset();
      opcode = ops[0];
      ena = 1'b1;
      tick();
      for (int k = 0; k < 6; k++) begin
         opcode = ops[k];
         push_instr(ops[k], 1'b0);
         for (int p = 0; p < 6; p++) begin
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
               errors++;
               $display("FAIL b2b op=%0d ph=%0d got=%h exp=%h", ops[k], p, outs, exp);
            end
            tick();
         end
      end
      ena = 1'b0;
   endtask

`ifdef WAIT_STATE_EN
   // mem_ready low for 3 cycles in F1: rd held, loads only on the ready cycle
   task automatic test_wait_state;
      do_reset();
      opcode = OP_LDA;
      ena = 1'b1;
      mem_ready = 1'b0;
      exp_q.push_back(V_ZERO);
      for (int i = 0; i < 3; i++) exp_q.push_back(8'h04);
      push_instr(OP_LDA, 1'b0);
      incs = 0;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) mem_ready = 1'b1;
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL wait cyc=%0d got=%h exp=%h", i, outs, exp);
         end
         if (i >= 1 && i <= 4 && inc_pc === 1'b1) incs++;
         tick();
      end
      checks++;
      if (incs !== 1) begin
         errors++;
         $display("FAIL wait_f1_inc_count got=%0d exp=1", incs);
      end
   endtask
`else
   // Without wait states mem_ready must have no effect on timing
   task automatic test_wait_state;
      do_reset();
      opcode = OP_LDA;
      ena = 1'b1;
      mem_ready = 1'b0;
      exp_q.push_back(V_ZERO);
      push_instr(OP_LDA, 1'b0);
      for (int i = 0; i < 7; i++) begin
         #1;
         exp = exp_q.pop_front();
         checks++;
         if (outs !== exp) begin
            errors++;
            $display("FAIL no_wait cyc=%0d got=%h exp=%h", i, outs, exp);
         end
         tick();
      end
      mem_ready = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_lda();
      test_skz();
      test_sto();
      test_hlt();
      test_jmp_ena_drop();
      test_back_to_back();
      test_wait_state();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
